// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: handshaked pipeline register with a one-entry skid buffer
// and a synchronous flush. in_ready, out_valid and count are decoded from the
// state register only, so no input has a combinational path to an output.
module pipe_skid_reg #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] skid;
   logic             in_fire;
   logic             out_fire;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign count     = state;

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Next-state and register-load decode; flush overrides every transition
   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      unique case (state)
         EMPTY: begin
            if (in_fire) begin
               load_main_in = 1'b1;
               state_nxt    = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main_in = 1'b1;
            end else if (in_fire) begin
               load_skid = 1'b1;
               state_nxt = FULL;
            end else if (out_fire) begin
               state_nxt = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               load_main_skid = 1'b1;
               state_nxt      = ONE;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      if (flush) begin
         state_nxt      = EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Main and skid data registers; they only change on a fill or a skid move
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data <= '0;
         skid     <= '0;
      end else begin
         if (load_main_in) begin
            out_data <= in_data;
         end else if (load_main_skid) begin
            out_data <= skid;
         end
         if (load_skid) begin
            skid <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed scenarios plus random valid/ready stress for
// pipe_skid_reg, with a queue-based reference model and scoreboard monitor.
module tb_pipe_skid_reg;

   localparam int unsigned W = 16;

   logic         clk;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [1:0]   count;

   int checks;
   int errors;

   // Reference model: the words accepted and not yet delivered, oldest first
   logic [W-1:0] q[$];

   pipe_skid_reg #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: samples on the falling edge, then advances the model
   // with the inputs that the next rising edge will see
   always @(negedge clk) begin
      int unsigned sz0;
      logic [W-1:0] exp_word;
      if (rst) begin
         q.delete();
      end else begin
         sz0 = q.size();
         check("mon_count", 32'(count), 32'(sz0));
         check("mon_in_ready", 32'(in_ready), 32'(sz0 < 2));
         check("mon_out_valid", 32'(out_valid), 32'(sz0 != 0));
         check("mon_inv_in_ready", 32'(in_ready), 32'(count != 2'd2));
         check("mon_inv_out_valid", 32'(out_valid), 32'(count != 2'd0));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("mon_spurious_out", 32'(out_data), 32'hDEAD_BEEF);
            end else begin
               exp_word = q.pop_front();
               check("mon_out_data", 32'(out_data), 32'(exp_word));
            end
         end
         if (flush) begin
            q.delete();
         end else if (in_valid && sz0 < 2) begin
            q.push_back(in_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset values before any clock edge
      #2;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Streaming at full rate
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0011;
      tick();
      check("stream_d0", 32'(out_data), 32'h11);
      check("stream_c0", 32'(count), 32'd1);
      in_data = 16'h0022;
      tick();
      check("stream_d1", 32'(out_data), 32'h22);
      check("stream_r1", 32'(in_ready), 32'd1);
      in_data = 16'h0033;
      tick();
      check("stream_d2", 32'(out_data), 32'h33);
      check("stream_c2", 32'(count), 32'd1);
      in_valid = 1'b0;
      tick();
      check("stream_drain", 32'(count), 32'd0);

      // Stall and skid
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h00A1;
      tick();
      in_data = 16'h00A2;
      tick();
      check("stall_count", 32'(count), 32'd2);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      in_data = 16'h00A3;
      tick();
      check("stall_hold_count", 32'(count), 32'd2);
      check("stall_hold_data", 32'(out_data), 32'hA1);
      out_ready = 1'b1;
      tick();
      check("skid_in_ready_back", 32'(in_ready), 32'd1);
      check("skid_d1", 32'(out_data), 32'hA2);
      tick();
      check("skid_d2", 32'(out_data), 32'hA3);
      in_valid = 1'b0;
      tick();
      check("skid_empty", 32'(count), 32'd0);

      // Flush while FULL with a word offered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h00B1;
      tick();
      in_data = 16'h00B2;
      tick();
      check("flush_pre_count", 32'(count), 32'd2);
      in_data = 16'h00FF;
      flush   = 1'b1;
      tick();
      check("flush_count", 32'(count), 32'd0);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("flush_still_empty", 32'(out_valid), 32'd0);

      // Reset mid-operation while FULL
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'h00C1;
      tick();
      in_data = 16'h00C2;
      tick();
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_data", 32'(out_data), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      tick();
      rst      = 1'b0;
      in_valid = 1'b1;
      in_data  = 16'h005A;
      tick();
      check("post_rst_data", 32'(out_data), 32'h5A);
      check("post_rst_valid", 32'(out_valid), 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();

      // Random valid/ready stress
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = W'($urandom);
         flush     = ($urandom_range(0, 63) == 0);
         tick();
      end
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      tick();
      check("final_drain", 32'(count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Handshaked pipeline register for the flow CPU: the consumer-side counterpart to the plain reset flop used between stages. It accepts a word from an upstream stage with valid/ready, holds it for the downstream stage, and absorbs one extra word in a skid entry, so backpressure never combinationally couples `out_ready` to `in_ready`. It also supports a synchronous flush for branch or exception squash.

## Interface
- `WIDTH`, default 32: payload width in bits.
- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous reset, active-high.
- `flush`  input  1  synchronous squash; empties both entries.
- `in_valid`  input  1  upstream word present.
- `in_ready`  output  1  block can accept a word; driven only from state registers.
- `in_data`  input  WIDTH  upstream payload.
- `out_valid`  output  1  main entry holds a word.
- `out_ready`  input  1  downstream accepts a word.
- `out_data`  output  WIDTH  main entry payload, driven directly from a register.
- `count`  output  2  occupancy: 0, 1 or 2.

## Operation
- Storage: a main register (`out_data`) and a skid register, each WIDTH bits.
- State machine with three states:
  - EMPTY: occupancy 0.
  - ONE: main entry valid.
  - FULL: main and skid entries valid.
- Handshake events:
  - In-fire = `in_valid & in_ready`.
  - Out-fire = `out_valid & out_ready`.
- Transitions, evaluated at each `clk` edge when `flush` = 0:
  - EMPTY, in-fire: main <= `in_data`; go to ONE.
  - ONE, in-fire and out-fire: main <= `in_data`; stay in ONE.
  - ONE, in-fire only: skid <= `in_data`; go to FULL.
  - ONE, out-fire only: go to EMPTY.
  - FULL, out-fire: main <= skid; go to ONE. No in-fire is possible in FULL.
  - No event: hold state and data.
- Derived outputs:
  - `in_ready` = (state != FULL).
  - `out_valid` = (state != EMPTY).
  - `count` = 0 / 1 / 2 for EMPTY / ONE / FULL.
- `flush` = 1 at an edge: go to EMPTY regardless of handshakes.
  - The in-fire word in that cycle is dropped.
  - An out-fire in that cycle is still counted as delivered by downstream.
  - Data registers keep their values; they are don't-care while invalid.
- Order: words leave in exactly the order they were accepted. No duplication, no loss except on flush.
- Data changes in the main register only on a fill or a skid-to-main move. It is stable while `out_valid` = 1 and `out_ready` = 0.

## Timing
- Reset, asynchronous and immediate:
  - state = EMPTY.
  - `out_valid` = 0, `in_ready` = 1, `count` = 0.
  - `out_data` = 0, skid = 0.
- Reset asserted mid-transfer discards both entries. The first edge after deassertion behaves as EMPTY.
- Latency: a word accepted at edge N is visible on `out_data` with `out_valid` = 1 immediately after edge N (1 cycle).
- Throughput: 1 word/cycle sustained when `out_ready` is held at 1.
- Backpressure: `in_ready` falls in the cycle after the skid fills, i.e. after a second accept while the output is stalled. It rises the cycle after the out-fire from FULL.
- There is no combinational path from `out_ready` or `in_valid` to any output.
- `flush` has priority over every transition, including a FULL state with a simultaneous out-fire.

## Test plan
- Reset: assert `rst` between edges.
  - Required without any clock edge: `out_valid` = 0, `in_ready` = 1, `count` = 0, `out_data` = 0.
- Streaming: `out_ready` = 1; present 0x11, 0x22, 0x33 on consecutive cycles.
  - Required: `out_data` shows 0x11, 0x22, 0x33 on consecutive cycles.
  - `count` stays at 1; `in_ready` never drops.
- Stall and skid: `out_ready` = 0; send 0xA1 then 0xA2.
  - Required: `count` = 2 and `in_ready` = 0, with 0xA3 held off.
  - Then raise `out_ready`: outputs are 0xA1, 0xA2, 0xA3 in order, and `in_ready` returns to 1 one cycle after the first out-fire.
- Flush while FULL, with `in_valid` = 1 carrying 0xFF.
  - Required: next cycle `count` = 0, `out_valid` = 0, and 0xFF never appears on the output.
- Reset mid-operation while FULL: pulse `rst`.
  - Required: immediately `count` = 0 and `out_data` = 0.
  - Next accepted word 0x5A appears on `out_data` one cycle after it is accepted.
- Random valid/ready stress over 10k cycles: a scoreboard confirms in-order, lossless delivery.
  - Also check `in_ready` = (`count` != 2) and `out_valid` = (`count` != 0) on every cycle.
